// File: rtl/rv_dmem_slave.sv
// Word-organised data RAM answering single-beat cyc/stb data-bus requests with a one-cycle ack.
// Optional wait states before the ack are enabled by defining RV_DMEM_WAIT_EN.
module rv_dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dbus_cyc_i,
  input  logic        dbus_stb_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_sel_i,
  input  logic [29:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  output logic [31:0] dbus_dat_o,
  output logic        dbus_ack_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           state_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             req;
  logic             inHit;
  logic             commitEn;
  logic             cWe;
  logic             cHit;
  logic [3:0]       cSel;
  logic [IDX_W-1:0] cIdx;
  logic [31:0]      cDat;

  assign req   = dbus_cyc_i & dbus_stb_i;
  // The window is aligned to its own size, so a hit is just a match on the upper address bits.
  assign inHit = (dbus_adr_i[29:IDX_W] == BASE_WORD[29:IDX_W]);

`ifdef RV_DMEM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [3:0]       waitCnt_q;
  logic             reqWe_q;
  logic             reqHit_q;
  logic [3:0]       reqSel_q;
  logic [IDX_W-1:0] reqIdx_q;
  logic [31:0]      reqDat_q;

  // Commit happens on the edge that enters ACK; from WAIT the latched request is used.
  assign commitEn = ((state_q == ST_IDLE) && req && (WAIT_LOAD == 4'd0)) ||
                    ((state_q == ST_WAIT) && dbus_cyc_i && (waitCnt_q == 4'd1));
  assign cWe  = (state_q == ST_IDLE) ? dbus_we_i  : reqWe_q;
  assign cHit = (state_q == ST_IDLE) ? inHit      : reqHit_q;
  assign cSel = (state_q == ST_IDLE) ? dbus_sel_i : reqSel_q;
  assign cIdx = (state_q == ST_IDLE) ? dbus_adr_i[IDX_W-1:0] : reqIdx_q;
  assign cDat = (state_q == ST_IDLE) ? dbus_dat_i : reqDat_q;
`else
  assign commitEn = (state_q == ST_IDLE) && req;
  assign cWe  = dbus_we_i;
  assign cHit = inHit;
  assign cSel = dbus_sel_i;
  assign cIdx = dbus_adr_i[IDX_W-1:0];
  assign cDat = dbus_dat_i;
`endif

  always_ff @(posedge clk_i) begin
    if (commitEn && cWe && cHit) begin
      for (int b = 0; b < 4; b++) begin
        if (cSel[b]) mem[cIdx][8*b +: 8] <= cDat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
`ifdef RV_DMEM_WAIT_EN
      waitCnt_q <= 4'd0;
      reqWe_q   <= 1'b0;
      reqHit_q  <= 1'b0;
      reqSel_q  <= 4'd0;
      reqIdx_q  <= '0;
      reqDat_q  <= 32'h0;
`endif
    end else begin
      ack_q <= 1'b0;
      if (commitEn && !cWe) dat_q <= cHit ? mem[cIdx] : 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
`ifdef RV_DMEM_WAIT_EN
            reqWe_q  <= dbus_we_i;
            reqHit_q <= inHit;
            reqSel_q <= dbus_sel_i;
            reqIdx_q <= dbus_adr_i[IDX_W-1:0];
            reqDat_q <= dbus_dat_i;
            if (WAIT_LOAD == 4'd0) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q   <= ST_WAIT;
              waitCnt_q <= WAIT_LOAD;
            end
`else
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
`endif
          end
        end
`ifdef RV_DMEM_WAIT_EN
        // Dropping cyc while waiting abandons the transfer before anything is committed.
        ST_WAIT: begin
          if (!dbus_cyc_i) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= 4'd0;
          end else if (waitCnt_q == 4'd1) begin
            state_q   <= ST_ACK;
            ack_q     <= 1'b1;
            waitCnt_q <= 4'd0;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
`endif
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbus_ack_o = ack_q;
  assign dbus_dat_o = dat_q;

endmodule

// File: tb/tb_rv_dmem_slave.sv
// Directed self-checking bench for rv_dmem_slave: reset, lane writes, window misses, back-to-back
// requests, async reset and (with RV_DMEM_WAIT_EN) wait states with cyc abort.
module tb_rv_dmem_slave;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef RV_DMEM_WAIT_EN
  localparam int unsigned WS = 3;
`else
  localparam int unsigned WS = 0;
`endif
  localparam int EXP_LAT = 1 + WS;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        dbus_cyc_i = 1'b0;
  logic        dbus_stb_i = 1'b0;
  logic        dbus_we_i = 1'b0;
  logic [3:0]  dbus_sel_i = 4'h0;
  logic [29:0] dbus_adr_i = 30'h0;
  logic [31:0] dbus_dat_i = 32'h0;
  logic [31:0] dbus_dat_o;
  logic        dbus_ack_o;

  int testsRun = 0;
  int testsFailed = 0;

  rv_dmem_slave #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .dbus_cyc_i(dbus_cyc_i),
    .dbus_stb_i(dbus_stb_i),
    .dbus_we_i(dbus_we_i),
    .dbus_sel_i(dbus_sel_i),
    .dbus_adr_i(dbus_adr_i),
    .dbus_dat_i(dbus_dat_i),
    .dbus_dat_o(dbus_dat_o),
    .dbus_ack_o(dbus_ack_o)
  );

  always #5 clk_i = ~clk_i;

  // One master transfer: stb stays high through the edge after ack, then extra acks are counted.
  task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                               input logic [31:0] dat, output int lat, output int acks,
                               output logic [31:0] rd);
    dbus_cyc_i = 1'b1;
    dbus_stb_i = 1'b1;
    dbus_we_i  = we;
    dbus_sel_i = sel;
    dbus_adr_i = adr;
    dbus_dat_i = dat;
    lat  = 0;
    acks = 0;
    while (acks == 0 && lat < 20) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
      if (dbus_ack_o) acks++;
    end
    rd = dbus_dat_o;
    @(posedge clk_i);
    #1;
    dbus_cyc_i = 1'b0;
    dbus_stb_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (dbus_ack_o) acks++;
    end
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    #1;
    testsRun++;
    if (dbus_ack_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ack: got %b expected 0", dbus_ack_o);
    end
    testsRun++;
    if (dbus_dat_o !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_dat: got %h expected 00000000", dbus_dat_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_write_read();
    int lat, acks;
    logic [31:0] rd;
    applyStimulus(1'b1, 4'hF, 30'h404, 32'hDEADBEEF, lat, acks, rd);
    testsRun++;
    if (lat !== EXP_LAT || acks !== 1) begin
      testsFailed++;
      $display("[TB] FAIL wr_timing: got lat=%0d acks=%0d expected lat=%0d acks=1", lat, acks, EXP_LAT);
    end
    testsRun++;
    if (rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL wr_dat_hold: got %h expected 00000000", rd);
    end
    applyStimulus(1'b0, 4'hF, 30'h404, 32'h0, lat, acks, rd);
    testsRun++;
    if (lat !== EXP_LAT || acks !== 1) begin
      testsFailed++;
      $display("[TB] FAIL rd_timing: got lat=%0d acks=%0d expected lat=%0d acks=1", lat, acks, EXP_LAT);
    end
    testsRun++;
    if (rd !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL rd_data: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat, acks;
    logic [31:0] rd;
    logic [31:0] exp [4] = '{32'h1122AA44, 32'h1122AA44, 32'hCC22AA44, 32'hCC22AA44};
    logic [3:0]  wsel [4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic [31:0] wdat [4] = '{32'h0000AA00, 32'hFFFFFFFF, 32'hCC000000, 32'h0};
    logic        wwe  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    applyStimulus(1'b1, 4'hF, 30'h405, 32'h11223344, lat, acks, rd);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(wwe[i], wsel[i], 30'h405, wdat[i], lat, acks, rd);
      testsRun++;
      if (acks !== 1) begin
        testsFailed++;
        $display("[TB] FAIL lane_ack_%0d: got %0d acks expected 1", i, acks);
      end
      // A sel=0000 read in the last step still returns the whole word.
      applyStimulus(1'b0, (i == 3) ? 4'h0 : 4'hF, 30'h405, 32'h0, lat, acks, rd);
      testsRun++;
      if (rd !== exp[i]) begin
        testsFailed++;
        $display("[TB] FAIL lane_data_%0d: got %h expected %h", i, rd, exp[i]);
      end
    end
  endtask

  task automatic test_miss();
    int lat, acks;
    logic [31:0] rd;
    applyStimulus(1'b1, 4'hF, 30'h400, 32'hA5A5A5A5, lat, acks, rd);
    applyStimulus(1'b1, 4'hF, 30'h40F, 32'h0F0F0F0F, lat, acks, rd);
    applyStimulus(1'b0, 4'hF, 30'h400, 32'h0, lat, acks, rd);
    applyStimulus(1'b0, 4'hF, 30'h410, 32'h0, lat, acks, rd);
    testsRun++;
    if (lat !== EXP_LAT || acks !== 1 || rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL miss_read: got lat=%0d acks=%0d dat=%h expected lat=%0d acks=1 dat=00000000",
               lat, acks, rd, EXP_LAT);
    end
    applyStimulus(1'b1, 4'hF, 30'h410, 32'h12345678, lat, acks, rd);
    testsRun++;
    if (acks !== 1) begin
      testsFailed++;
      $display("[TB] FAIL miss_write_ack: got %0d acks expected 1", acks);
    end
    applyStimulus(1'b0, 4'hF, 30'h400, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'hA5A5A5A5) begin
      testsFailed++;
      $display("[TB] FAIL miss_no_alias: got %h expected a5a5a5a5", rd);
    end
    applyStimulus(1'b0, 4'hF, 30'h3FF, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL miss_below: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, acks;
    logic [31:0] rd;
    applyStimulus(1'b0, 4'hF, 30'h404, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'hDEADBEEF || acks !== 1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_read: got dat=%h acks=%0d expected deadbeef acks=1", rd, acks);
    end
    applyStimulus(1'b1, 4'hF, 30'h404, 32'hCAFEF00D, lat, acks, rd);
    testsRun++;
    if (lat !== EXP_LAT || acks !== 1 || dbus_dat_o !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL b2b_write: got lat=%0d acks=%0d dat=%h expected lat=%0d acks=1 dat=deadbeef",
               lat, acks, dbus_dat_o, EXP_LAT);
    end
    applyStimulus(1'b0, 4'hF, 30'h404, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'hCAFEF00D || acks !== 1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_reread: got dat=%h acks=%0d expected cafef00d acks=1", rd, acks);
    end
  endtask

  task automatic test_async_reset();
    int lat, acks;
    logic [31:0] rd;
    dbus_cyc_i = 1'b1;
    dbus_stb_i = 1'b1;
    dbus_we_i  = 1'b0;
    dbus_sel_i = 4'hF;
    dbus_adr_i = 30'h405;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    testsRun++;
    if (dbus_ack_o !== 1'b0 || dbus_dat_o !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got ack=%b dat=%h expected ack=0 dat=00000000",
               dbus_ack_o, dbus_dat_o);
    end
    #1 rst_i = 1'b0;
    dbus_cyc_i = 1'b0;
    dbus_stb_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(1'b0, 4'hF, 30'h405, 32'h0, lat, acks, rd);
    testsRun++;
    if (lat !== EXP_LAT || acks !== 1 || rd !== 32'hCC22AA44) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_read: got lat=%0d acks=%0d dat=%h expected lat=%0d acks=1 dat=cc22aa44",
               lat, acks, rd, EXP_LAT);
    end
  endtask

`ifdef RV_DMEM_WAIT_EN
  task automatic test_wait_abort();
    int lat, acks;
    logic [31:0] rd;
    logic [31:0] held;
    applyStimulus(1'b1, 4'hF, 30'h406, 32'h01020304, lat, acks, rd);
    held = dbus_dat_o;
    dbus_cyc_i = 1'b1;
    dbus_stb_i = 1'b1;
    dbus_we_i  = 1'b1;
    dbus_sel_i = 4'hF;
    dbus_adr_i = 30'h406;
    dbus_dat_i = 32'hFFFFFFFF;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    dbus_cyc_i = 1'b0;
    dbus_stb_i = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (dbus_ack_o) acks++;
    end
    testsRun++;
    if (acks !== 0 || dbus_dat_o !== held) begin
      testsFailed++;
      $display("[TB] FAIL abort: got acks=%0d dat=%h expected acks=0 dat=%h", acks, dbus_dat_o, held);
    end
    applyStimulus(1'b0, 4'hF, 30'h406, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'h01020304) begin
      testsFailed++;
      $display("[TB] FAIL abort_ram: got %h expected 01020304", rd);
    end
    dbus_cyc_i = 1'b1;
    dbus_stb_i = 1'b1;
    dbus_we_i  = 1'b1;
    dbus_dat_i = 32'h55555555;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    dbus_cyc_i = 1'b0;
    dbus_stb_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(1'b0, 4'hF, 30'h406, 32'h0, lat, acks, rd);
    testsRun++;
    if (rd !== 32'h01020304) begin
      testsFailed++;
      $display("[TB] FAIL reset_write_lost: got %h expected 01020304", rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_miss();
    test_back_to_back();
    test_async_reset();
`ifdef RV_DMEM_WAIT_EN
    test_wait_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
